m_pktarb2: RTL

- Packet-atomic, two-input round-robin arbiter for MIC 64-bit packet streams (TVALID/TREADY/TDATA/TLAST).
- Merges two packet generators, or a generator and a responder, onto one MIC port or packet sink.
- Grant is held from a packet's header beat until its TLAST beat transfers, so beats of different packets never interleave.
- Keeps per-input packet counters for bench and debug visibility.

---
 rtl/m_pktarb2.sv | 130 +++++++++++++
 1 files changed

// File: rtl/m_pktarb2.sv
// m_pktarb2: packet-atomic two-input round-robin arbiter for 64-bit MIC streams.
// Latency: zero; the selected input is wired straight through to the output.
// Backpressure: O_TREADY reaches the selected input only; the other input sees TREADY=0.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   I0_* / I1_*          input packet streams (TVALID/TREADY/TDATA/TLAST)
//   O_*                  merged output packet stream
//   grant                one-hot input currently forwarded, 2'b00 when none
//   pkt_count0/1         packets completed per input, wrapping counters
module m_pktarb2 #(
  parameter string NAME        = "PktArb",
  parameter int    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   I0_TVALID,
  output logic                   I0_TREADY,
  input  logic [63:0]            I0_TDATA,
  input  logic                   I0_TLAST,
  input  logic                   I1_TVALID,
  output logic                   I1_TREADY,
  input  logic [63:0]            I1_TDATA,
  input  logic                   I1_TLAST,
  output logic                   O_TVALID,
  input  logic                   O_TREADY,
  output logic [63:0]            O_TDATA,
  output logic                   O_TLAST,
  output logic [1:0]             grant,
  output logic [COUNT_WIDTH-1:0] pkt_count0,
  output logic [COUNT_WIDTH-1:0] pkt_count1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;      // input that most recently completed a packet
  logic   sel_vld;   // some input is selected this cycle
  logic   sel_idx;   // which input is selected
  logic   done;      // selected input transfers its TLAST beat this cycle

  // Selection, forwarding and next state.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = 1'b0;
    state_nxt = state;

    case (state)
      IDLE: begin
        if (I0_TVALID && I1_TVALID) begin
          // Contention: the input that did not finish last goes next.
          sel_vld = 1'b1;
          sel_idx = ~last;
        end else if (I0_TVALID) begin
          sel_vld = 1'b1;
          sel_idx = 1'b0;
        end else if (I1_TVALID) begin
          sel_vld = 1'b1;
          sel_idx = 1'b1;
        end
      end
      BUSY0: begin
        sel_vld = 1'b1;
        sel_idx = 1'b0;
      end
      BUSY1: begin
        sel_vld = 1'b1;
        sel_idx = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    grant     = sel_vld ? {sel_idx, ~sel_idx} : 2'b00;
    O_TVALID  = sel_vld && (sel_idx ? I1_TVALID : I0_TVALID);
    O_TDATA   = sel_vld ? (sel_idx ? I1_TDATA : I0_TDATA) : 64'd0;
    O_TLAST   = sel_vld && (sel_idx ? I1_TLAST : I0_TLAST);
    I0_TREADY = sel_vld && !sel_idx && O_TREADY;
    I1_TREADY = sel_vld && sel_idx && O_TREADY;
    done      = O_TVALID && O_TREADY && O_TLAST;

    // Any selection that does not complete a packet this cycle locks the
    // grant, including a stalled header in IDLE, so a waiting beat can never
    // be swapped for the other input's data.
    if (sel_vld) begin
      if (done) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = sel_idx ? BUSY1 : BUSY0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      state <= state_nxt;
      if (done) begin
        last <= sel_idx;
      end
      if (done && !sel_idx) begin
        pkt_count0 <= pkt_count0 + COUNT_WIDTH'(1);
      end
      if (done && sel_idx) begin
        pkt_count1 <= pkt_count1 + COUNT_WIDTH'(1);
      end
    end
  end

  // A granted source that offered a beat must keep it offered until it transfers.
  property p_hold_valid(logic g, logic v);
    @(posedge clk) disable iff (reset) (g && v && !O_TREADY) |=> v;
  endproperty

  a_hold0: assert property (p_hold_valid(grant[0], I0_TVALID))
    else $warning("%s: *** I0_TVALID dropped while granted with beat untransferred", NAME);
  a_hold1: assert property (p_hold_valid(grant[1], I1_TVALID))
    else $warning("%s: *** I1_TVALID dropped while granted with beat untransferred", NAME);

endmodule
